ic74x323: RTL

IC74X323 -- requirements
Module: ic74x323

---
 rtl/ic74x323.sv | 99 +++++++++
 1 files changed

// File: rtl/ic74x323.sv
// 74x323 octal universal shift/storage register: per-bit storage cells,
// shared mode decode, tri-state I/O pins and continuous serial taps.

module ic74x323_cell (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] mode,
  input  logic       from_lo,
  input  logic       from_hi,
  input  logic       pin,
  output logic       q
);
  always_ff @(posedge clk) begin
    if (!clr_n) q <= 1'b0;
    else begin
      case (mode)
        2'b01:   q <= from_lo;
        2'b10:   q <= from_hi;
        // xor with 0 turns a floating or unknown pin into x instead of z
        2'b11:   q <= pin ^ 1'b0;
        default: q <= q;
      endcase
    end
  end
endmodule

module ic74x323 (
  input  logic port1,
  input  logic port2,
  input  logic port3,
  inout  wire  port4,
  inout  wire  port5,
  inout  wire  port6,
  inout  wire  port7,
  output logic port8,
  input  logic port9,
  input  logic port10,
  input  logic port11,
  input  logic port12,
  inout  wire  port13,
  inout  wire  port14,
  inout  wire  port15,
  inout  wire  port16,
  output logic port17,
  input  logic port18,
  input  logic port19,
  input  logic port20
);
  localparam int NUM_LANES = 8;

  logic [1:0]           mode;
  logic [NUM_LANES-1:0] q;
  logic [NUM_LANES-1:0] lo_in;
  logic [NUM_LANES-1:0] hi_in;
  logic [NUM_LANES-1:0] pin_in;
  logic                 drv;
  logic                 unused;

  assign unused = ^{port10, port20};
  assign mode   = {port19, port1};

  // Bit i sees bit i-1 (SR at the bottom) and bit i+1 (SL at the top).
  assign lo_in  = {q[NUM_LANES-2:0], port11};
  assign hi_in  = {port18, q[NUM_LANES-1:1]};
  assign pin_in = {port16, port4, port15, port5, port14, port6, port13, port7};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ic74x323_cell u_cell (
      .clk     (port12),
      .clr_n   (port9),
      .mode    (mode),
      .from_lo (lo_in[i]),
      .from_hi (hi_in[i]),
      .pin     (pin_in[i]),
      .q       (q[i])
    );
  end

  // Pins are released during parallel load so the source can drive them.
  assign drv = !port2 && !port3 && (mode != 2'b11);

  assign port7  = drv ? q[0] : 1'bz;
  assign port13 = drv ? q[1] : 1'bz;
  assign port6  = drv ? q[2] : 1'bz;
  assign port14 = drv ? q[3] : 1'bz;
  assign port5  = drv ? q[4] : 1'bz;
  assign port15 = drv ? q[5] : 1'bz;
  assign port4  = drv ? q[6] : 1'bz;
  assign port16 = drv ? q[7] : 1'bz;

  assign port8  = q[0];
  assign port17 = q[NUM_LANES-1];

  always_ff @(posedge port12) begin
    assert (!$isunknown(port9)) else $fatal(1, "ic74x323: port9 (CLR_n) is x/z at clock edge");
    assert (!$isunknown(port1)) else $fatal(1, "ic74x323: port1 (S0) is x/z at clock edge");
    assert (!$isunknown(port19)) else $fatal(1, "ic74x323: port19 (S1) is x/z at clock edge");
  end
endmodule
